// File: rtl/axi_read_arbiter_pkg.sv
// Shared definitions for the cache-refill AXI read arbiter: bus widths, AXI
// encodings, arbitration modes and the arbiter state type.
package axi_read_arbiter_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } arb_state_t;

endpackage

// File: rtl/axi_rr_pick.sv
// Combinational N-way picker: first asserted valid at or after ptr, wrapping.
// A ptr of 0 degenerates to lowest-index-wins.
module axi_rr_pick #(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          found
);

  always_comb begin
    int cand;
    // NOTE: every output gets a default before the search loop so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    grant = '0;
    index = '0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < N; i++) begin
      cand = (int'(ptr) + i) % N;
      if (!found && valid[cand]) begin
        grant[cand] = 1'b1;
        index       = IW'(cand);
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read channel between NUM_REQ cache refill masters, one whole
// burst at a time; AR fields are registered, R beats are passed through.
module axi_read_arbiter
  import axi_read_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ARB_MODE   = ARB_RR,
  parameter int ADDR_WIDTH = axi_read_arbiter_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = axi_read_arbiter_pkg::DATA_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_arvalid,
  output logic [NUM_REQ-1:0]                  req_arready,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_araddr,
  input  logic [NUM_REQ-1:0][7:0]             req_arlen,
  input  logic [NUM_REQ-1:0][2:0]             req_arsize,
  input  logic [NUM_REQ-1:0][1:0]             req_arburst,
  output logic [NUM_REQ-1:0]                  req_rvalid,
  input  logic [NUM_REQ-1:0]                  req_rready,
  output logic [DATA_WIDTH-1:0]               req_rdata,
  output logic [NUM_REQ-1:0]                  req_rlast,
  output logic                                m_arvalid,
  input  logic                                m_arready,
  output logic [ADDR_WIDTH-1:0]               m_araddr,
  output logic [7:0]                          m_arlen,
  output logic [2:0]                          m_arsize,
  output logic [1:0]                          m_arburst,
  input  logic                                m_rvalid,
  output logic                                m_rready,
  input  logic [DATA_WIDTH-1:0]               m_rdata,
  input  logic                                m_rlast,
  output logic [$clog2(NUM_REQ)-1:0]          grant_id,
  output logic                                busy,
  output logic                                protocol_err
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_t          state, next_state;
  logic [IW-1:0]       rr_ptr, pick_ptr, pick_idx, next_ptr;
  logic [NUM_REQ-1:0]  pick_onehot;
  logic                pick_any;
  logic [7:0]          beat_cnt;
  logic                r_hs;

  assign pick_ptr  = (ARB_MODE == ARB_FIXED) ? '0 : rr_ptr;
  assign next_ptr  = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign r_hs      = (state == DATA) && m_rvalid && req_rready[grant_id];
  assign req_rdata = m_rdata;
  assign busy      = (state != IDLE);

  axi_rr_pick #(.N(NUM_REQ)) u_pick (
    .valid (req_arvalid),
    .ptr   (pick_ptr),
    .grant (pick_onehot),
    .index (pick_idx),
    .found (pick_any)
  );

  always_comb begin
    next_state  = state;
    req_arready = '0;
    req_rvalid  = '0;
    req_rlast   = '0;
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    case (state)
      IDLE: begin
        // Gated by rst so nothing is accepted while reset is held.
        if (pick_any && !rst) begin
          req_arready = pick_onehot;
          next_state  = ADDR;
        end
      end
      ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready) next_state = DATA;
      end
      DATA: begin
        req_rvalid[grant_id] = m_rvalid;
        req_rlast[grant_id]  = m_rlast;
        m_rready             = req_rready[grant_id];
        if (r_hs && m_rlast) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the AR holding registers are ordinary flops and reset too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      grant_id     <= '0;
      beat_cnt     <= '0;
      m_araddr     <= '0;
      m_arlen      <= '0;
      m_arsize     <= '0;
      m_arburst    <= '0;
      protocol_err <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (pick_any) begin
            m_araddr  <= req_araddr[pick_idx];
            m_arlen   <= req_arlen[pick_idx];
            m_arsize  <= req_arsize[pick_idx];
            m_arburst <= req_arburst[pick_idx];
            grant_id  <= pick_idx;
            beat_cnt  <= '0;
          end
        end
        DATA: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            // Last beat must coincide exactly with beat arlen.
            if (m_rlast != (beat_cnt == m_arlen)) protocol_err <= 1'b1;
            if (m_rlast && (ARB_MODE == ARB_RR)) rr_ptr <= next_ptr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
